pwm8_gen: RTL
=============

// Module: pwm8_gen
// PURPOSE
//   Downstream consumer of the free-running 8-bit counter: turns the count into a PWM waveform.
//   Each period is 256 counts. The duty comes from a valid/ready shadow register.
//   A new duty is committed only at counter wrap, so the output never glitches mid-period.
//   Also emits a one-cycle period tick for downstream timing.
// PARAMETERS
//   WIDTH     8   counter / duty width in bits
//   DEAD_CYC  2   dead-time in clocks between pwm_out and pwm_n_out; used only when PWM8_DEADTIME_EN is defined
// PORTS
//   clock        in   1      clock, rising-edge
//   reset        in   1      reset, asynchronous, active-high
//   en           in   1      block enable; low forces IDLE
//   cnt_in       in   WIDTH  count from upstream counter (increments by 1, wraps FF->00)
//   duty_valid   in   1      duty write request
//   duty_data    in   WIDTH  requested duty (high for duty_data counts of 256)
//   duty_ready   out  1      shadow register empty; write accepted when valid&&ready
//   pwm_out      out  1      PWM output, registered
//   period_tick  out  1      one-cycle pulse, one clock after wrap detected while RUN/SYNC
//   pwm_n_out    out  1      complementary output with dead-time (PWM8_DEADTIME_EN only)
// BEHAVIOUR
//   Reset state (async):
//     pwm_out=0, period_tick=0, pwm_n_out=0, duty_ready=1.
//     shadow=0, active=0, pending=0, cnt_prev=0, state=IDLE.
//   cnt_prev: registered copy of cnt_in every clock, regardless of state.
//   wrap: combinational, wrap = (cnt_in < cnt_prev). FF->00 is the only wrap in normal use.
//   Duty handshake:
//     - On valid&&ready: shadow<=duty_data, pending<=1. duty_ready drops on the next cycle.
//     - duty_data is ignored when ready=0; the requester holds valid until ready.
//   Commit on a wrap in SYNC or RUN:
//     - If pending: active<=shadow, pending<=0, duty_ready returns to 1 on the next cycle.
//     - Simultaneous accept+wrap with pending=0: the new value goes to shadow only.
//       It is committed at the following wrap, never the current one.
//   FSM:
//     IDLE: pwm_out=0, no ticks, no commit. en=1 -> SYNC.
//     SYNC: pwm_out=0. On wrap: commit, -> RUN.
//     RUN:  pwm_out <= (cnt_in < active). On wrap: commit, then pwm_out uses the new active on that same edge.
//     Any state with en=0 -> IDLE on next edge; pwm_out=0 on that edge.
//       shadow, active and pending are retained.
//   Latency: cnt_in sampled at edge k drives pwm_out after edge k (1 cycle).
//     period_tick asserts one cycle after the wrap edge.
//   Boundaries:
//     - active=0: pwm_out constantly 0.
//     - active=255: pwm_out is low only for cnt_in=255 (255/256 duty).
//     - Full 100% duty is not representable, by decision.
//     - Upstream counter reset to 0 mid-period is a wrap (cnt_in<cnt_prev): commit happens and a tick fires.
//     - Reset mid-operation clears everything, including a pending duty.
// CONFIGURATION
//   PWM8_DEADTIME_EN defined:
//     - pwm_n_out is the registered complement of pwm_out.
//     - Each rising edge of either output is delayed DEAD_CYC clocks after the other output falls.
//     - The two outputs are never high together.
//     - IDLE forces both outputs to 0.
//   PWM8_DEADTIME_EN undefined:
//     - pwm_n_out port is absent.
//     - pwm_out is exactly as in BEHAVIOUR, with no dead-time logic.
// STRUCTURE
//   Package pwm8_pkg:
//     - state enum {IDLE,SYNC,RUN} (2-bit encodings)
//     - default WIDTH and DEAD_CYC constants
//   Sub-module pwm8_deadtime: dead-time counter and complementary output, instantiated only under PWM8_DEADTIME_EN.
//   Top holds the handshake, wrap detect, FSM and compare.
// TESTING (drive cnt_in from the existing 8-bit counter instance)
//   1. Reset held 3 cycles, then released with en=0 -> pwm_out=0, duty_ready=1, period_tick never pulses.
//   2. Write duty 64, en=1 -> SYNC until 00; then pwm_out high for 64 clocks, low 192; period_tick every 256 clocks.
//   3. Write 200 in mid-period while running at 64 -> duty_ready=0; 64 holds to period end; next period is 200 high; duty_ready=1 after the wrap.
//   4. Accept duty 10 on the exact cycle cnt_in goes FF->00 with pending=0 -> current period keeps old duty; 10 applies from the following wrap.
//   5. Duty 0 -> pwm_out always 0. Duty 255 -> pwm_out low only at cnt_in=255.
//   6. Deassert en mid-period -> pwm_out=0 next edge. Re-enable -> SYNC waits for wrap before output resumes. Async reset mid-RUN -> all outputs 0 immediately.
//   (PWM8_DEADTIME_EN build: additionally check pwm_out&pwm_n_out never both 1 and DEAD_CYC=2 gaps at each transition.)

Source files
------------

// File: rtl/pwm8_pkg.sv
// Shared types and defaults for the 8-bit PWM generator.
package pwm8_pkg;

    localparam int unsigned PwmWidth   = 8;
    localparam int unsigned PwmDeadCyc = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSync = 2'd1,
        StRun  = 2'd2
    } pwm8_state_e;

endpackage

// File: rtl/pwm8_deadtime.sv
// Complementary output stage with dead-time: after either output falls, the
// other may rise only once DEAD_CYC clocks have passed with both low.
module pwm8_deadtime #(
    parameter int unsigned DEAD_CYC = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic force_off,
    input  logic pwm_ref,
    output logic pwm_p,
    output logic pwm_n
);

    localparam int unsigned CntW = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;

    logic            p_q, p_d, n_q, n_d;
    logic [CntW-1:0] dead_q, dead_d;
    logic            want_p, want_n, dead_ok;

    assign want_p  = pwm_ref & ~force_off;
    assign want_n  = ~pwm_ref & ~force_off;
    // A count of 1 means this edge completes the gap.
    assign dead_ok = (dead_q <= CntW'(1));

    // Falling edges are immediate and restart the gap; rising edges wait for it.
    always_comb begin
        p_d    = p_q;
        n_d    = n_q;
        dead_d = (dead_q != '0) ? dead_q - CntW'(1) : '0;
        if (p_q && !want_p) begin
            p_d    = 1'b0;
            dead_d = CntW'(DEAD_CYC);
        end else if (!p_q && want_p && !n_q && dead_ok) begin
            p_d = 1'b1;
        end
        if (n_q && !want_n) begin
            n_d    = 1'b0;
            dead_d = CntW'(DEAD_CYC);
        end else if (!n_q && want_n && !p_q && dead_ok) begin
            n_d = 1'b1;
        end
    end

    // Output and gap-counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p_q    <= 1'b0;
            n_q    <= 1'b0;
            dead_q <= '0;
        end else begin
            p_q    <= p_d;
            n_q    <= n_d;
            dead_q <= dead_d;
        end
    end

    assign pwm_p = p_q;
    assign pwm_n = n_q;

endmodule

// File: rtl/pwm8_gen.sv
// PWM generator driven by an external free-running counter. Duty is written
// through a one-entry valid/ready shadow and committed only at counter wrap.
// Optional complementary dead-time output: define PWM8_DEADTIME_EN.
module pwm8_gen
    import pwm8_pkg::*;
#(
    parameter int unsigned WIDTH    = PwmWidth,
    parameter int unsigned DEAD_CYC = PwmDeadCyc
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             duty_valid,
    input  logic [WIDTH-1:0] duty_data,
    output logic             duty_ready,
    output logic             pwm_out,
`ifdef PWM8_DEADTIME_EN
    output logic             pwm_n_out,
`endif
    output logic             period_tick
);

    pwm8_state_e      state_q, state_d;
    logic [WIDTH-1:0] cnt_prev_q;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic             pending_q, pending_d;
    logic             pwm_q, pwm_d;
    logic             tick_q, tick_d;
    logic             wrap, running, accept;

    // Any backwards step of the count (normal FF->00 or an upstream reset) is a wrap.
    assign wrap       = (cnt_in < cnt_prev_q);
    assign running    = en && (state_q != StIdle);
    assign duty_ready = ~pending_q;
    assign accept     = duty_valid && duty_ready;

    // Shadow/active duty update. Accept only happens with pending clear, so it
    // never collides with a commit; a same-cycle accept lands in shadow only.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (running && wrap && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (accept) begin
            shadow_d  = duty_data;
            pending_d = 1'b1;
        end
    end

    // FSM next state, compare and tick. The wrap edge that leaves SYNC already
    // drives the compare so the first period is full length.
    always_comb begin
        state_d = state_q;
        pwm_d   = 1'b0;
        tick_d  = 1'b0;
        if (!en) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: state_d = StSync;
                StSync: begin
                    if (wrap) begin
                        state_d = StRun;
                        pwm_d   = (cnt_in < active_d);
                        tick_d  = 1'b1;
                    end
                end
                StRun: begin
                    pwm_d  = (cnt_in < active_d);
                    tick_d = wrap;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Previous count, sampled every clock regardless of state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_prev_q <= '0;
        else       cnt_prev_q <= cnt_in;
    end

    // Duty shadow/active registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            pwm_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pwm_q   <= pwm_d;
            tick_q  <= tick_d;
        end
    end

    assign period_tick = tick_q;

`ifdef PWM8_DEADTIME_EN
    logic idle;
    assign idle = (state_q == StIdle);

    pwm8_deadtime #(
        .DEAD_CYC (DEAD_CYC)
    ) u_deadtime (
        .clock     (clock),
        .reset     (reset),
        .force_off (idle),
        .pwm_ref   (pwm_q),
        .pwm_p     (pwm_out),
        .pwm_n     (pwm_n_out)
    );
`else
    logic unused_dead_cyc;
    assign unused_dead_cyc = ^DEAD_CYC;
    assign pwm_out         = pwm_q;
`endif

endmodule
